writeback_stage: RTL and testbench

//   Final pipeline stage (MEM/WB register + write-back) and the write-side owner of reg_file's

---
 rtl/writeback_stage_if.sv | 40 ++++
 rtl/writeback_stage.sv | 93 +++++++++
 tb/tb_writeback_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Memory-stage -> write-back bundle: incoming instruction, stall back to upstream,
// reg_file write port, decode forwarding bus and retirement counter.
interface writeback_stage_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_RegWrite;
   logic              in_ALUtoReg;
   logic              in_dual;
   logic [ADDR_W-1:0] in_rd1;
   logic [ADDR_W-1:0] in_rd2;
   logic [WIDTH-1:0]  in_alu_result;
   logic [WIDTH-1:0]  in_mem_data;
   logic [WIDTH-1:0]  in_second_data;
   logic              flush;
   logic              busy;
   logic              RegWrite;
   logic [ADDR_W-1:0] write_address;
   logic [WIDTH-1:0]  write_data;
   logic              fwd_valid;
   logic [ADDR_W-1:0] fwd_addr;
   logic [WIDTH-1:0]  fwd_data;
   logic [CNT_W-1:0]  retired_count;

   modport master (
      output in_valid, in_RegWrite, in_ALUtoReg, in_dual, in_rd1, in_rd2,
             in_alu_result, in_mem_data, in_second_data, flush,
      input  busy, RegWrite, write_address, write_data,
             fwd_valid, fwd_addr, fwd_data, retired_count
   );

   modport slave (
      input  in_valid, in_RegWrite, in_ALUtoReg, in_dual, in_rd1, in_rd2,
             in_alu_result, in_mem_data, in_second_data, flush,
      output busy, RegWrite, write_address, write_data,
             fwd_valid, fwd_addr, fwd_data, retired_count
   );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB register plus reg_file write-port owner; dual-destination instructions take two
// consecutive write cycles while busy stalls upstream. Write port follows capture by 1 cycle.
module writeback_stage #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 16
) (
   input logic            clk,
   input logic            rst,
   writeback_stage_if.slave wb
);
   typedef enum logic {IDLE, SECOND} state_t;

   state_t            state_q;
   logic              r_valid_q;
   logic              r_regwrite_q;
   logic              r_dual_q;
   logic [ADDR_W-1:0] r_rd1_q;
   logic [ADDR_W-1:0] r_rd2_q;
   logic [WIDTH-1:0]  r_wdata_q;
   logic [WIDTH-1:0]  r_second_q;
   logic [CNT_W-1:0]  count_q;

   logic              busy;
   logic              accept_d;
   logic [WIDTH-1:0]  r_wdata_d;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              retire;

   assign busy      = (state_q == IDLE) & r_valid_q & r_regwrite_q & r_dual_q;
   assign accept_d  = wb.in_valid & ~busy & ~wb.flush;
   assign r_wdata_d = wb.in_ALUtoReg ? wb.in_alu_result : wb.in_mem_data;
   assign retire    = (state_q == SECOND) |
                      (r_valid_q & ~(r_regwrite_q & r_dual_q));

   // The register only stalls on the first write of a dual; the edge leaving SECOND
   // must load the next instruction, otherwise the dual would be replayed forever.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         r_valid_q    <= 1'b0;
         r_regwrite_q <= 1'b0;
         r_dual_q     <= 1'b0;
         r_rd1_q      <= '0;
         r_rd2_q      <= '0;
         r_wdata_q    <= '0;
         r_second_q   <= '0;
         count_q      <= '0;
      end else begin
         if (!busy) begin
            r_valid_q    <= accept_d;
            r_regwrite_q <= wb.in_RegWrite;
            r_dual_q     <= wb.in_dual;
            r_rd1_q      <= wb.in_rd1;
            r_rd2_q      <= wb.in_rd2;
            r_wdata_q    <= r_wdata_d;
            r_second_q   <= wb.in_second_data;
         end
         case (state_q)
            IDLE:    state_q <= busy ? SECOND : IDLE;
            SECOND:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (retire) count_q <= count_q + 1'b1;
      end
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (state_q == SECOND) begin
         wr_en   = 1'b1;
         wr_addr = r_rd2_q;
         wr_data = r_second_q;
      end else if (r_valid_q & r_regwrite_q) begin
         wr_en   = 1'b1;
         wr_addr = r_rd1_q;
         wr_data = r_wdata_q;
      end
   end

   assign wb.busy          = busy;
   assign wb.RegWrite      = wr_en;
   assign wb.write_address = wr_addr;
   assign wb.write_data    = wr_data;
   assign wb.fwd_valid     = wr_en;
   assign wb.fwd_addr      = wr_addr;
   assign wb.fwd_data      = wr_data;
   assign wb.retired_count = count_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; a second instance with a 4-bit counter shares the
// stimulus so the retirement counter wrap can be observed.
module tb_writeback_stage;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   writeback_stage_if #(.WIDTH(16), .ADDR_W(3), .CNT_W(16)) wb ();
   writeback_stage_if #(.WIDTH(16), .ADDR_W(3), .CNT_W(4))  wbn ();

   writeback_stage #(.WIDTH(16), .ADDR_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .wb(wb.slave)
   );
   writeback_stage #(.WIDTH(16), .ADDR_W(3), .CNT_W(4)) dut_n (
      .clk(clk), .rst(rst), .wb(wbn.slave)
   );

   assign wbn.in_valid       = wb.in_valid;
   assign wbn.in_RegWrite    = wb.in_RegWrite;
   assign wbn.in_ALUtoReg    = wb.in_ALUtoReg;
   assign wbn.in_dual        = wb.in_dual;
   assign wbn.in_rd1         = wb.in_rd1;
   assign wbn.in_rd2         = wb.in_rd2;
   assign wbn.in_alu_result  = wb.in_alu_result;
   assign wbn.in_mem_data    = wb.in_mem_data;
   assign wbn.in_second_data = wb.in_second_data;
   assign wbn.flush          = wb.flush;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic a2r, input logic dual,
                        input logic [2:0] rd1, input logic [2:0] rd2,
                        input logic [15:0] alu, input logic [15:0] mem,
                        input logic [15:0] sec, input logic fl);
      wb.in_valid       = v;
      wb.in_RegWrite    = rw;
      wb.in_ALUtoReg    = a2r;
      wb.in_dual        = dual;
      wb.in_rd1         = rd1;
      wb.in_rd2         = rd2;
      wb.in_alu_result  = alu;
      wb.in_mem_data    = mem;
      wb.in_second_data = sec;
      wb.flush          = fl;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wr(input string tag, input logic we, input logic [2:0] addr,
                           input logic [15:0] data);
      check_vec({tag, ".we"},   32'(wb.RegWrite),      32'(we));
      check_vec({tag, ".addr"}, 32'(wb.write_address), 32'(addr));
      check_vec({tag, ".data"}, 32'(wb.write_data),    32'(data));
      check_vec({tag, ".fv"},   32'(wb.fwd_valid),     32'(we));
      check_vec({tag, ".fa"},   32'(wb.fwd_addr),      32'(addr));
      check_vec({tag, ".fd"},   32'(wb.fwd_data),      32'(data));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      // reset held with a valid writing instruction presented
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 16'h1111, 16'h0, 16'h0, 1'b0);
      repeat (3) step();
      check_wr("rst", 1'b0, 3'd0, 16'h0);
      check_vec("rst.busy", 32'(wb.busy), 32'd0);
      check_vec("rst.cnt", 32'(wb.retired_count), 32'd0);

      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 16'h1234, 16'hFFFF, 16'h0, 1'b0);
      step();
      check_wr("single", 1'b1, 3'd3, 16'h1234);
      check_vec("single.cnt_pre", 32'(wb.retired_count), 32'd0);

      drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 3'd0, 16'h0F0F, 16'hBEEF, 16'h0, 1'b0);
      step();
      check_wr("memsel", 1'b1, 3'd5, 16'hBEEF);
      check_vec("memsel.cnt", 32'(wb.retired_count), 32'd1);

      drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 16'hAAAA, 16'h0, 16'h5555, 1'b0);
      step();
      check_wr("dual1", 1'b1, 3'd1, 16'hAAAA);
      check_vec("dual1.busy", 32'(wb.busy), 32'd1);
      check_vec("dual1.cnt", 32'(wb.retired_count), 32'd2);
      // upstream moves on to R4 but must be held off by busy
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 3'd0, 16'h4444, 16'h0, 16'h0, 1'b0);
      step();
      check_wr("dual2", 1'b1, 3'd2, 16'h5555);
      check_vec("dual2.busy", 32'(wb.busy), 32'd0);
      check_vec("dual2.cnt", 32'(wb.retired_count), 32'd2);
      step();
      check_wr("after_dual", 1'b1, 3'd4, 16'h4444);
      check_vec("after_dual.cnt", 32'(wb.retired_count), 32'd3);

      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 3'd0, 16'h7777, 16'h0, 16'h0, 1'b0);
      step();
      check_vec("pre_flush.cnt", 32'(wb.retired_count), 32'd4);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 3'd0, 16'h6666, 16'h0, 16'h0, 1'b1);
      #1;
      check_wr("flush_keep", 1'b1, 3'd7, 16'h7777);
      step();
      check_wr("flushed", 1'b0, 3'd0, 16'h0);
      check_vec("flushed.cnt", 32'(wb.retired_count), 32'd5);

      // valid instruction that writes nothing still retires
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 16'h3333, 16'h0, 16'h0, 1'b0);
      step();
      check_wr("nowrite", 1'b0, 3'd0, 16'h0);
      check_vec("nowrite.cnt", 32'(wb.retired_count), 32'd5);
      idle();
      step();
      check_vec("nowrite.cnt2", 32'(wb.retired_count), 32'd6);
      step();
      check_vec("bubble.cnt", 32'(wb.retired_count), 32'd6);

      // same destination twice: second value lands last
      drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 3'd5, 16'h0001, 16'h0, 16'h0002, 1'b0);
      step();
      idle();
      check_wr("same1", 1'b1, 3'd5, 16'h0001);
      step();
      check_wr("same2", 1'b1, 3'd5, 16'h0002);
      step();
      check_vec("same.cnt", 32'(wb.retired_count), 32'd7);

      drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 16'hAAAA, 16'h0, 16'h5555, 1'b0);
      step();
      check_vec("rstsec.busy", 32'(wb.busy), 32'd1);
      rst = 1'b0;
      idle();
      step();
      check_wr("rstsec", 1'b0, 3'd0, 16'h0);
      check_vec("rstsec.cnt", 32'(wb.retired_count), 32'd0);
      rst = 1'b1;
      step();
      check_wr("rstsec.no_rd2", 1'b0, 3'd0, 16'h0);
      check_vec("rstsec.busy2", 32'(wb.busy), 32'd0);

      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 3'(i), 3'd0, 16'(i), 16'h0, 16'h0, 1'b0);
         step();
      end
      idle();
      step();
      check_vec("wrap.wide", 32'(wb.retired_count), 32'd16);
      check_vec("wrap.narrow", 32'(wbn.retired_count), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      step();
      idle();
      step();
      check_vec("wrap.narrow1", 32'(wbn.retired_count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
